taxi_gmii_rx_ctrl: RTL

//  Sequencer for the GMII frame receiver (taxi_axis_gmii_rx). Drives the receiver's clk_enable,
//  mii_select and cfg_rx_enable, and applies speed/enable changes only at frame boundaries and

---
 rtl/taxi_gmii_rx_ctrl_if.sv | 38 +++
 rtl/taxi_gmii_rx_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/taxi_gmii_rx_ctrl_if.sv
// Control/status bundle between taxi_gmii_rx_ctrl and its surroundings.
// The slave side is the controller; the master side is software plus receiver monitors.
interface taxi_gmii_rx_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cfg_enable_req;
    logic [1:0]       cfg_speed;
    logic             stat_clear;
    logic             mon_rx_dv;
    logic             mon_tvalid;
    logic             mon_tlast;
    logic             start_packet;
    logic             error_bad_frame;
    logic             error_bad_fcs;
    logic             rx_clk_enable;
    logic             rx_mii_select;
    logic             rx_cfg_rx_enable;
    logic [1:0]       sts_state;
    logic [1:0]       sts_speed;
    logic             sts_drain_to;
    logic [CNT_W-1:0] stat_frames;
    logic [CNT_W-1:0] stat_bad_frame;
    logic [CNT_W-1:0] stat_bad_fcs;

    modport slave (
        input  cfg_enable_req, cfg_speed, stat_clear, mon_rx_dv, mon_tvalid, mon_tlast,
        input  start_packet, error_bad_frame, error_bad_fcs,
        output rx_clk_enable, rx_mii_select, rx_cfg_rx_enable, sts_state, sts_speed,
        output sts_drain_to, stat_frames, stat_bad_frame, stat_bad_fcs
    );

    modport master (
        output cfg_enable_req, cfg_speed, stat_clear, mon_rx_dv, mon_tvalid, mon_tlast,
        output start_packet, error_bad_frame, error_bad_fcs,
        input  rx_clk_enable, rx_mii_select, rx_cfg_rx_enable, sts_state, sts_speed,
        input  sts_drain_to, stat_frames, stat_bad_frame, stat_bad_fcs
    );
endinterface

// File: rtl/taxi_gmii_rx_ctrl.sv
// GMII receiver sequencer: clock-enable divider, frame-boundary enable/speed sequencing
// and saturating receive statistics.
//
// state      | meaning
// DISABLED   | receiver off; pending speed changes are applied here
// WAIT_IDLE  | waiting for IDLE_GAP consecutive idle strobes before enabling
// ACTIVE     | receiver enabled
// DRAIN      | disable requested mid-frame; waiting for frame end or timeout
module taxi_gmii_rx_ctrl #(
    parameter int CNT_W         = 32,
    parameter int IDLE_GAP      = 8,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    taxi_gmii_rx_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_DISABLED  = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    localparam int IDLE_W  = $clog2(IDLE_GAP + 1);
    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_GAP - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    state_t             r_state;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_rx_en;
    logic               r_drain_to;
    logic               r_in_frame;
    logic [5:0]         r_div_cnt;
    logic               r_clk_en;
    logic [1:0]         r_speed;
    logic               r_mii_sel;
    logic [CNT_W-1:0]   r_frames;
    logic [CNT_W-1:0]   r_bad_frame;
    logic [CNT_W-1:0]   r_bad_fcs;

    logic [1:0] w_cfg_speed;
    logic       w_mismatch;
    logic       w_apply;
    logic       w_frame_end;
    logic       w_stop;
    logic [5:0] w_reload;

    assign w_cfg_speed = (bus.cfg_speed == 2'd3) ? 2'd2 : bus.cfg_speed;
    assign w_mismatch  = (w_cfg_speed != r_speed);
    assign w_apply     = w_mismatch && (r_state == ST_DISABLED || r_state == ST_WAIT_IDLE);
    assign w_frame_end = bus.mon_tvalid & bus.mon_tlast;
    assign w_stop      = !bus.cfg_enable_req || w_mismatch;

    always_comb begin
        case (r_speed)
            2'd0:    w_reload = 6'd49;
            2'd1:    w_reload = 6'd4;
            default: w_reload = 6'd0;
        endcase
    end

    // Strobe output lags the counter by one register so every output stays registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_clk_en  <= 1'b0;
            r_speed   <= 2'd2;
            r_mii_sel <= 1'b0;
        end else if (w_apply) begin
            r_speed   <= w_cfg_speed;
            r_mii_sel <= (w_cfg_speed != 2'd2);
            r_div_cnt <= '0;
            r_clk_en  <= 1'b0;
        end else begin
            r_clk_en  <= (r_div_cnt == 6'd0);
            r_div_cnt <= (r_div_cnt == 6'd0) ? w_reload : r_div_cnt - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_DISABLED;
            r_idle_cnt  <= '0;
            r_drain_cnt <= '0;
            r_rx_en     <= 1'b0;
            r_drain_to  <= 1'b0;
            r_in_frame  <= 1'b0;
        end else begin
            r_drain_to <= 1'b0;
            if (bus.start_packet)
                r_in_frame <= 1'b1;
            else if (w_frame_end)
                r_in_frame <= 1'b0;

            case (r_state)
                ST_DISABLED: begin
                    if (bus.cfg_enable_req && !w_mismatch) begin
                        r_state    <= ST_WAIT_IDLE;
                        r_idle_cnt <= '0;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!bus.cfg_enable_req) begin
                        r_state <= ST_DISABLED;
                    end else if (w_mismatch) begin
                        r_idle_cnt <= '0;
                    end else if (r_clk_en) begin
                        if (bus.mon_rx_dv) begin
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt == IDLE_LAST) begin
                            r_state <= ST_ACTIVE;
                            r_rx_en <= 1'b1;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_stop) begin
                        if (r_in_frame) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= '0;
                        end else begin
                            r_state <= ST_DISABLED;
                            r_rx_en <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_frame_end) begin
                        r_state <= ST_DISABLED;
                        r_rx_en <= 1'b0;
                    end else if (r_drain_cnt == DRAIN_LAST) begin
                        r_state    <= ST_DISABLED;
                        r_rx_en    <= 1'b0;
                        r_drain_to <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_DISABLED;
                    r_rx_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frames    <= '0;
            r_bad_frame <= '0;
            r_bad_fcs   <= '0;
        end else if (bus.stat_clear) begin
            r_frames    <= '0;
            r_bad_frame <= '0;
            r_bad_fcs   <= '0;
        end else begin
            if (w_frame_end && r_frames != CNT_MAX)
                r_frames <= r_frames + 1'b1;
            if (bus.error_bad_frame && r_bad_frame != CNT_MAX)
                r_bad_frame <= r_bad_frame + 1'b1;
            if (bus.error_bad_fcs && r_bad_fcs != CNT_MAX)
                r_bad_fcs <= r_bad_fcs + 1'b1;
        end
    end

    assign bus.rx_clk_enable    = r_clk_en;
    assign bus.rx_mii_select    = r_mii_sel;
    assign bus.rx_cfg_rx_enable = r_rx_en;
    assign bus.sts_state        = r_state;
    assign bus.sts_speed        = r_speed;
    assign bus.sts_drain_to     = r_drain_to;
    assign bus.stat_frames      = r_frames;
    assign bus.stat_bad_frame   = r_bad_frame;
    assign bus.stat_bad_fcs     = r_bad_fcs;
endmodule
